// File: rtl/demux_1to4_tdm.sv
// demux_1to4_tdm
//   Time-division 1-to-4 demultiplexer. Serial slot words arrive on din,
//   one per valid beat, in lane order A, B, C, D. Slots A..C are collected
//   in shadow registers. The slot-D beat commits the whole frame to the
//   registered lane outputs and raises a one-cycle frame_valid strobe.
//
// Ports
//   clk          : rising-edge clock
//   rst          : synchronous active-high reset (priority over all inputs)
//   din          : serial slot word (WIDTH bits)
//   din_valid    : din carries a slot word this cycle
//   sync         : with din_valid, marks din as slot 0 (lane A)
//   A, B, C, D   : lanes of the last completed frame
//   s0, s1       : slot counter; {s1,s0} is the slot for the next valid word
//   frame_valid  : one-cycle pulse when A..D hold a new frame
//   sync_err     : one-cycle pulse when an early sync aborted a frame
//   frame_cnt    : completed-frame count, wraps 255 -> 0
module demux_1to4_tdm #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] D,
  output logic             s0,
  output logic             s1,
  output logic             frame_valid,
  output logic             sync_err,
  output logic [7:0]       frame_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic [WIDTH-1:0] sha_q, sha_d;
  logic [WIDTH-1:0] shb_q, shb_d;
  logic [WIDTH-1:0] shc_q, shc_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             fv_q, fv_d;
  logic             serr_q, serr_d;
  logic [7:0]       cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      slot_q  <= '0;
      sha_q   <= '0;
      shb_q   <= '0;
      shc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      fv_q    <= 1'b0;
      serr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      sha_q   <= sha_d;
      shb_q   <= shb_d;
      shc_q   <= shc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      fv_q    <= fv_d;
      serr_q  <= serr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    sha_d   = sha_q;
    shb_d   = shb_q;
    shc_d   = shc_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;
    fv_d    = 1'b0;
    serr_d  = 1'b0;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        // Unaligned words are dropped until the first sync beat.
        if (din_valid && sync) begin
          sha_d   = din;
          slot_d  = 2'b01;
          state_d = RUN;
        end
      end

      RUN: begin
        if (din_valid) begin
          if (sync && (slot_q != 2'b00)) begin
            // Early sync: restart the frame at slot A; outputs keep the old frame.
            serr_d = 1'b1;
            sha_d  = din;
            slot_d = 2'b01;
          end else begin
            unique case (slot_q)
              2'b00: sha_d = din;
              2'b01: shb_d = din;
              2'b10: shc_d = din;
              2'b11: begin
                // Slot D bypasses the shadows so all four lanes update together.
                a_d   = sha_q;
                b_d   = shb_q;
                c_d   = shc_q;
                d_d   = din;
                fv_d  = 1'b1;
                cnt_d = cnt_q + 8'd1;
              end
              default: ;
            endcase
            slot_d = slot_q + 2'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign A           = a_q;
  assign B           = b_q;
  assign C           = c_q;
  assign D           = d_q;
  assign s0          = slot_q[0];
  assign s1          = slot_q[1];
  assign frame_valid = fv_q;
  assign sync_err    = serr_q;
  assign frame_cnt   = cnt_q;

endmodule
